// File: rtl/cpu_pkg.sv
// Shared RV32I memory-operation types and helpers.
// Imported by execute and by the load/store unit.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_LB  = 3'b000,
        MEM_LH  = 3'b001,
        MEM_LW  = 3'b010,
        MEM_SB  = 3'b011,
        MEM_LBU = 3'b100,
        MEM_LHU = 3'b101,
        MEM_SH  = 3'b110,
        MEM_SW  = 3'b111
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    function automatic logic is_load(mem_op_e op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(mem_op_e op);
        return !is_load(op);
    endfunction

    function automatic mem_size_e size(mem_op_e op);
        mem_size_e s;
        unique case (op)
            MEM_LB, MEM_LBU, MEM_SB: s = SZ_B;
            MEM_LH, MEM_LHU, MEM_SH: s = SZ_H;
            default:                 s = SZ_W;
        endcase
        return s;
    endfunction

    function automatic logic is_misaligned(mem_op_e op, logic [1:0] lo);
        logic bad;
        unique case (size(op))
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/gnt/rvalid bus.
// master = load/store unit, slave = memory.
interface load_store_unit_if;
    import cpu_pkg::*;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Byte-lane extraction and sign/zero extension
// of a loaded word.
module load_align
    import cpu_pkg::*;
(
    input  mem_op_e         op,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[8*addr +: 8];
    assign half_v = rdata[16*addr[1] +: 16];

    // Select lane and extend according to the load type.
    always_comb begin
        data = rdata;
        unique case (op)
            MEM_LB:  data = {{24{byte_v[7]}}, byte_v};
            MEM_LBU: data = {24'b0, byte_v};
            MEM_LH:  data = {{16{half_v[15]}}, half_v};
            MEM_LHU: data = {16'b0, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: performs one load or store per
// transaction over the req/gnt/rvalid bus.
module load_store_unit
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  mem_op_e         ex_op,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    load_store_unit_if.master bus,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            st_done,
    output logic            misaligned,
    output logic [XLEN-1:0] misaligned_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e          state, state_n;
    mem_op_e         op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] ld_data_q;
    logic            mis_q;
    logic            take;
    logic            bad;
    logic [XLEN-1:0] aligned;
    logic [3:0]      be;
    logic [XLEN-1:0] lane_wdata;

    assign take = ex_valid && ex_ready;
    assign bad  = is_misaligned(ex_op, ex_addr[1:0]);

    load_align u_align (
        .op    (op_q),
        .addr  (addr_q[1:0]),
        .rdata (bus.mem_rdata),
        .data  (aligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state; misaligned requests never leave IDLE.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (take && !bad) state_n = REQ;
            REQ:    if (bus.mem_gnt)
                        state_n = is_store(op_q) ? DONE : WAIT_R;
            WAIT_R: if (bus.mem_rvalid) state_n = DONE;
            DONE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Store byte enables and lane-replicated data.
    always_comb begin
        be         = 4'b1111;
        lane_wdata = wdata_q;
        unique case (op_q)
            MEM_SB: begin
                be         = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            MEM_SH: begin
                be         = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    // Bus and pipeline outputs decoded from state.
    always_comb begin
        ex_ready      = (state == IDLE);
        bus.mem_req   = (state == REQ);
        bus.mem_we    = (state == REQ) && is_store(op_q);
        bus.mem_be    = (state == REQ) ? be : 4'b0000;
        bus.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        bus.mem_wdata = lane_wdata;
        wb_valid      = (state == DONE) && is_load(op_q);
        st_done       = (state == DONE) && is_store(op_q);
        wb_rd         = rd_q;
        wb_data       = ld_data_q;
        misaligned    = mis_q;
        misaligned_addr = addr_q;
    end

    // Latch the transaction and capture load data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= MEM_LB;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            ld_data_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            mis_q <= take && bad;
            if (take) begin
                op_q    <= ex_op;
                addr_q  <= ex_addr;
                wdata_q <= ex_wdata;
                rd_q    <= ex_rd;
            end
            if (state == WAIT_R && bus.mem_rvalid)
                ld_data_q <= aligned;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Expected values are hand-computed constants.
module tb_load_store_unit;
    import cpu_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            ex_valid;
    logic            ex_ready;
    mem_op_e         ex_op;
    logic [31:0]     ex_addr;
    logic [31:0]     ex_wdata;
    logic [4:0]      ex_rd;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [31:0]     wb_data;
    logic            st_done;
    logic            misaligned;
    logic [31:0]     misaligned_addr;

    int checks;
    int failures;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_op           (ex_op),
        .ex_addr         (ex_addr),
        .ex_wdata        (ex_wdata),
        .ex_rd           (ex_rd),
        .bus             (bus),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .st_done         (st_done),
        .misaligned      (misaligned),
        .misaligned_addr (misaligned_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input mem_op_e op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_addr  = addr;
        ex_wdata = wdata;
        ex_rd    = rd;
        check("ready_before_accept", {31'b0, ex_ready}, 32'd1);
        step();
        ex_valid = 1'b0;
    endtask

    task automatic load_test(input string tag, input mem_op_e op,
                             input logic [31:0] addr,
                             input logic [31:0] rdata,
                             input logic [4:0] rd,
                             input logic [31:0] exp, input int gdly);
        send(op, addr, 32'h0, rd);
        for (int i = 0; i < gdly; i++) begin
            bus.mem_rvalid = (i == 1);
            bus.mem_rdata  = ~rdata;
            check({tag, "_req_hold"}, {31'b0, bus.mem_req}, 32'd1);
            check({tag, "_ready_low"}, {31'b0, ex_ready}, 32'd0);
            step();
        end
        bus.mem_rvalid = 1'b0;
        check({tag, "_req"}, {31'b0, bus.mem_req}, 32'd1);
        check({tag, "_we"}, {31'b0, bus.mem_we}, 32'd0);
        check({tag, "_be"}, {28'b0, bus.mem_be}, 32'hF);
        check({tag, "_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        check({tag, "_req_drop"}, {31'b0, bus.mem_req}, 32'd0);
        step();
        bus.mem_rvalid = 1'b0;
        check({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd1);
        check({tag, "_wb_data"}, wb_data, exp);
        check({tag, "_wb_rd"}, {27'b0, wb_rd}, {27'b0, rd});
        step();
        check({tag, "_wb_pulse"}, {31'b0, wb_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, ex_ready}, 32'd1);
    endtask

    task automatic store_test(input string tag, input mem_op_e op,
                              input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata,
                              input int gdly);
        send(op, addr, wdata, 5'd0);
        for (int i = 0; i <= gdly; i++) begin
            bus.mem_rvalid = (i == 1);
            check({tag, "_req"}, {31'b0, bus.mem_req}, 32'd1);
            check({tag, "_we"}, {31'b0, bus.mem_we}, 32'd1);
            check({tag, "_be"}, {28'b0, bus.mem_be}, {28'b0, exp_be});
            check({tag, "_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
            check({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
            check({tag, "_ready_low"}, {31'b0, ex_ready}, 32'd0);
            check({tag, "_no_done"}, {31'b0, st_done}, 32'd0);
            if (i < gdly) step();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt    = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        check({tag, "_st_done"}, {31'b0, st_done}, 32'd1);
        check({tag, "_req_drop"}, {31'b0, bus.mem_req}, 32'd0);
        check({tag, "_no_wb"}, {31'b0, wb_valid}, 32'd0);
        step();
        check({tag, "_done_pulse"}, {31'b0, st_done}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, ex_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        ex_valid       = 1'b0;
        ex_op          = MEM_LW;
        ex_addr        = '0;
        ex_wdata       = '0;
        ex_rd          = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (3) step();
        rst_n = 1'b1;

        check("rst_ready", {31'b0, ex_ready}, 32'd1);
        check("rst_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_be", {28'b0, bus.mem_be}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_st_done", {31'b0, st_done}, 32'd0);
        check("rst_mis", {31'b0, misaligned}, 32'd0);
        check("rst_mis_addr", misaligned_addr, 32'd0);

        load_test("lw", MEM_LW, 32'h100, 32'hDEADBEEF, 5'd7,
                  32'hDEADBEEF, 0);
        load_test("lb3", MEM_LB, 32'h103, 32'h80FF7F01, 5'd3,
                  32'hFFFFFF80, 0);
        load_test("lbu3", MEM_LBU, 32'h103, 32'h80FF7F01, 5'd4,
                  32'h00000080, 0);
        load_test("lh2", MEM_LH, 32'h102, 32'h80FF7F01, 5'd5,
                  32'hFFFF80FF, 0);
        load_test("lhu2", MEM_LHU, 32'h102, 32'h80FF7F01, 5'd6,
                  32'h000080FF, 0);
        load_test("lb1", MEM_LB, 32'h101, 32'h80FF7F01, 5'd8,
                  32'h0000007F, 0);
        load_test("lh0", MEM_LH, 32'h100, 32'h80FF7F01, 5'd9,
                  32'h00007F01, 0);
        load_test("lb_rd0", MEM_LB, 32'h102, 32'h80FF7F01, 5'd0,
                  32'hFFFFFFFF, 0);
        load_test("lw_wait", MEM_LW, 32'h304, 32'hCAFEF00D, 5'd31,
                  32'hCAFEF00D, 3);

        store_test("sh6", MEM_SH, 32'h206, 32'h1234ABCD, 4'b1100,
                   32'hABCDABCD, 0);
        store_test("sh4", MEM_SH, 32'h204, 32'h1234ABCD, 4'b0011,
                   32'hABCDABCD, 0);
        store_test("sb1", MEM_SB, 32'h201, 32'h000000CD, 4'b0010,
                   32'hCDCDCDCD, 0);
        store_test("sb3", MEM_SB, 32'h203, 32'hFFFFFF5A, 4'b1000,
                   32'h5A5A5A5A, 0);
        store_test("sw_wait", MEM_SW, 32'h208, 32'h11223344, 4'b1111,
                   32'h11223344, 5);

        ex_valid = 1'b1;
        ex_op    = MEM_LW;
        ex_addr  = 32'h101;
        step();
        check("mis_pulse", {31'b0, misaligned}, 32'd1);
        check("mis_addr", misaligned_addr, 32'h101);
        check("mis_no_req", {31'b0, bus.mem_req}, 32'd0);
        check("mis_ready", {31'b0, ex_ready}, 32'd1);
        ex_op   = MEM_LH;
        ex_addr = 32'h203;
        step();
        ex_valid = 1'b0;
        check("mis2_pulse", {31'b0, misaligned}, 32'd1);
        check("mis2_addr", misaligned_addr, 32'h203);
        check("mis2_no_req", {31'b0, bus.mem_req}, 32'd0);
        step();
        check("mis_end", {31'b0, misaligned}, 32'd0);
        check("mis_idle_req", {31'b0, bus.mem_req}, 32'd0);
        check("mis_ready2", {31'b0, ex_ready}, 32'd1);

        send(MEM_LW, 32'h400, 32'h0, 5'd12);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        check("rstw_req", {31'b0, bus.mem_req}, 32'd0);
        check("rstw_busy", {31'b0, ex_ready}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rstw_idle", {31'b0, ex_ready}, 32'd1);
        check("rstw_no_wb", {31'b0, wb_valid}, 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h77777777;
        step();
        bus.mem_rvalid = 1'b0;
        check("late_rv_no_wb", {31'b0, wb_valid}, 32'd0);
        check("late_rv_ready", {31'b0, ex_ready}, 32'd1);
        check("late_rv_data", wb_data, 32'd0);
        step();
        check("late_rv_no_wb2", {31'b0, wb_valid}, 32'd0);
        load_test("lw_after_rst", MEM_LW, 32'h408, 32'h0BADF00D, 5'd2,
                  32'h0BADF00D, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the RV32I pipeline. Accepts one decoded load or store per transaction from the execute stage (effective address, store data, destination register) and performs the data-memory access over a req/gnt/rvalid bus. For loads it returns the byte-lane-extracted, sign- or zero-extended result to writeback. It is the consumer of the execute stage's LB/LH/LW/LBU/LHU/SB/SH/SW path and stalls execute through a ready handshake.

## Interface
- XLEN, 32, data and address width; only 32 is supported.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  execute presents a memory operation.
- ex_ready  out  1  unit can accept; transfer occurs when ex_valid && ex_ready.
- ex_op  in  3  mem_op_e: MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW.
- ex_addr  in  XLEN  effective address (rs1 + imm).
- ex_wdata  in  XLEN  rs2 value for stores; ignored for loads.
- ex_rd  in  5  load destination register.
- mem_req  out  1  bus request; held until granted.
- mem_we  out  1  1 = write.
- mem_addr  out  XLEN  word address; bits [1:0] are always 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid this cycle.
- mem_rdata  in  XLEN  read data word.
- wb_valid  out  1  one-cycle pulse: load result valid.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  extended load result.
- st_done  out  1  one-cycle pulse: store accepted by memory.
- misaligned  out  1  one-cycle pulse: misaligned access rejected.
- misaligned_addr  out  XLEN  offending address, valid with the misaligned pulse.

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE. Reset state is IDLE.
- IDLE: ex_ready=1. On transfer, latch op/addr/wdata/rd.
  - Misaligned (halfword with addr[0]=1, or word with addr[1:0]≠0): no bus access; misaligned=1 and misaligned_addr=addr next cycle; remain in IDLE.
  - Otherwise go to REQ.
- REQ: mem_req=1, outputs stable until mem_gnt. On gnt: store → DONE; load → WAIT_R.
- WAIT_R: on mem_rvalid, capture the extracted, extended data → DONE.
- DONE: load → wb_valid=1; store → st_done=1. Then → IDLE.
- ex_ready=0 in REQ, WAIT_R and DONE.
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0]; wdata = {4{b}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{h}}.
  - SW: be = 4'b1111.
- Loads drive mem_be=4'b1111 and mem_we=0.
- Load extraction:
  - byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- rd=0 loads still pulse wb_valid with wb_rd=0; the register file discards the write.
- mem_rvalid outside WAIT_R and mem_gnt outside REQ are ignored.

## Timing
- Reset values: mem_req, mem_we, mem_be, wb_valid, st_done, misaligned = 0; mem_addr, mem_wdata, wb_rd, wb_data, misaligned_addr = 0; ex_ready=1 from the first cycle after reset.
- Best case (gnt in the same cycle as req, rvalid the next cycle): accept at cycle 0, req at 1, rvalid at 2, wb_valid at 3. Store: st_done at 2 after gnt at 1.
- Next accept is earliest at the cycle after DONE.
- Misaligned: pulse at cycle 1; a new transfer can be accepted at cycle 1.
- Reset asserted in any state: next edge returns to IDLE and all pulses are 0. An rvalid arriving after reset is dropped.

## Structure
- cpu_pkg holds mem_op_e, the MEM_* encodings and the is_load/is_store/size helper functions; execute imports the same package.
- One sub-module: load_align, combinational; inputs op, addr[1:0], rdata; output extended data.

## Test plan
- LW at 0x100, gnt at once, rdata 0xDEADBEEF one cycle later → wb_valid at cycle 3, wb_data 0xDEADBEEF, wb_rd as sent.
- LB at 0x103 with rdata 0x80FF7F01 → wb_data 0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SH at 0x206 with wdata 0x1234ABCD → mem_addr 0x204, mem_be 4'b1100, mem_wdata 0xABCDABCD. SB at 0x201 → be 4'b0010.
- LW at 0x101 → misaligned pulse with misaligned_addr 0x101; mem_req never asserted; ex_ready stays 1.
- mem_gnt withheld 5 cycles → mem_req, addr, be, wdata stable throughout; ex_ready=0; a stray rvalid during REQ is ignored.
- rst_n low during WAIT_R → IDLE next cycle, no wb_valid; a late rvalid is dropped; a following LW completes normally.
